// File: rtl/ram_master_pkg.sv
// ram_master_pkg: shared RAM bus widths, depth and the ram_master state type.
// Houses package InstructionStruct.
package InstructionStruct;
  localparam int DWIDTH = 16;
  localparam int AWIDTH = 4;
  localparam int MEMDEPTH = 12;
  typedef enum logic [1:0] {IDLE, WR, RD, RSP} ram_master_state_t;
  function automatic logic [AWIDTH-1:0] next_addr(input logic [AWIDTH-1:0] a);
    return (a == AWIDTH'(MEMDEPTH - 1)) ? '0 : a + 1'b1;
  endfunction
endpackage

// File: rtl/ram_master.sv
// ram_master: single-initiator load/store FSM for the shared tristate RAM bus.
// Define RAM_MASTER_BURST_EN to honour req_len (1-4 beat loads with address wrap).
module ram_master
  import InstructionStruct::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  input  logic [1:0]        req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic [AWIDTH-1:0] ram_addr,
  inout  wire  [DWIDTH-1:0] ram_data,
  output logic              ram_rdEn,
  output logic              ram_wrEn,
  output logic              busy
);
  ram_master_state_t state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic last_q, last_d, up_q;
`ifdef RAM_MASTER_BURST_EN
  logic [1:0] beats_q, beats_d;
`else
  logic unused_len;
  assign unused_len = ^req_len;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      last_q <= 1'b0;
      up_q <= 1'b0;
`ifdef RAM_MASTER_BURST_EN
      beats_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      last_q <= last_d;
      up_q <= 1'b1;
`ifdef RAM_MASTER_BURST_EN
      beats_q <= beats_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    last_d = last_q;
`ifdef RAM_MASTER_BURST_EN
    beats_d = beats_q;
`endif
    case (state_q)
      IDLE: if (req_valid && req_ready) begin
        addr_d = req_addr;
        wdata_d = req_wdata;
        state_d = req_write ? WR : RD;
`ifdef RAM_MASTER_BURST_EN
        beats_d = req_write ? 2'd0 : req_len;
`endif
      end
      WR: begin
        rdata_d = '0;
        last_d = 1'b1;
        state_d = RSP;
      end
      RD: begin
        rdata_d = ram_data;
`ifdef RAM_MASTER_BURST_EN
        last_d = (beats_q == 2'd0);
`else
        last_d = 1'b1;
`endif
        state_d = RSP;
      end
      RSP: if (rsp_ready) begin
`ifdef RAM_MASTER_BURST_EN
        state_d = (beats_q == 2'd0) ? IDLE : RD;
        if (beats_q != 2'd0) begin
          beats_d = beats_q - 2'd1;
          addr_d = next_addr(addr_q);
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  // up_q holds off req_ready until the first clock edge after reset release
  assign req_ready = up_q && (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_last = last_q;
  assign ram_addr = addr_q;
  assign ram_rdEn = (state_q == RD);
  assign ram_wrEn = (state_q == WR);
  assign busy = (state_q != IDLE);
  assign ram_data = (state_q == WR) ? wdata_q : 'z;
endmodule
